// File: rtl/if_id_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_queue_if
// Bundles the fetch-side and decode-side signals of the IF/ID instruction
// queue so the queue and its neighbours connect through one port.
//
// Signals:
//   stall[5:0]   pipeline stall vector (queue uses bit 2, ID stall)
//   flush        branch taken in ID, discard queued and in-flight fetches
//   if_valid     fetch word on if_pc/if_inst is valid this cycle
//   if_pc        address of the fetched instruction
//   if_inst      fetched instruction word
//   id_pc        registered PC presented to ID
//   id_inst      registered instruction presented to ID
//   id_valid     id_pc/id_inst hold a real instruction (0 = bubble)
//   stallreq_if  queue full, upstream must hold the PC
//   level        current entry count, 0..DEPTH
//
// Modports:
//   master  pipeline side: drives stall/flush/fetch, observes ID outputs
//   slave   the queue itself
// -----------------------------------------------------------------------------
interface if_id_queue_if #(
    parameter int AW = 2
);
    logic [5:0]  stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        stallreq_if;
    logic [AW:0] level;

    modport master (
        output stall, flush, if_valid, if_pc, if_inst,
        input  id_pc, id_inst, id_valid, stallreq_if, level
    );

    modport slave (
        input  stall, flush, if_valid, if_pc, if_inst,
        output id_pc, id_inst, id_valid, stallreq_if, level
    );
endinterface

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Decoupling queue between instruction fetch and decode. Fetched {pc, inst}
// pairs are held in a circular FIFO; the head is moved into the ID registers
// whenever ID is not stalled. An empty queue presents a bubble to ID.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    if_id_queue_if.slave (stall, flush, fetch inputs; ID outputs,
//          stallreq_if, level)
//
// Build option:
//   IFQ_BYPASS_EN  when defined, a fetch arriving while the queue is empty
//                  and ID is consuming goes straight to the ID registers,
//                  saving one cycle of latency.
// -----------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_queue_if.slave  bus
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Entry storage; not reset, contents only matter behind the pointers.
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic [31:0]   id_inst_q, id_inst_d;
    logic          id_valid_q, id_valid_d;

    logic consume;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic bypass;
    logic push_en;

    // Only the ID stall bit matters here; fold the rest so they are
    // visibly intentionally ignored.
    logic unused_stall;
    assign unused_stall = ^{bus.stall[5:3], bus.stall[1:0]};

    assign consume = ~bus.stall[2];
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = consume && !empty;
    // A full queue can still accept a word in the same cycle it pops one.
    assign push    = bus.if_valid && !bus.flush && (!full || pop);

`ifdef IFQ_BYPASS_EN
    assign bypass  = empty && consume && bus.if_valid && !bus.flush;
`else
    assign bypass  = 1'b0;
`endif

    // A bypassed word goes straight to ID and never occupies an entry.
    assign push_en = push && !bypass;

    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        if (bus.flush) begin
            rptr_d     = '0;
            wptr_d     = '0;
            count_d    = '0;
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
        end else begin
            if (push_en) begin
                wptr_d = wptr_q + 1'b1;
            end

            if (pop) begin
                rptr_d     = rptr_q + 1'b1;
                id_pc_d    = mem_pc[rptr_q];
                id_inst_d  = mem_inst[rptr_q];
                id_valid_d = 1'b1;
            end else if (bypass) begin
                id_pc_d    = bus.if_pc;
                id_inst_d  = bus.if_inst;
                id_valid_d = 1'b1;
            end else if (consume) begin
                // ID advanced but nothing to give it: bubble.
                id_pc_d    = '0;
                id_inst_d  = '0;
                id_valid_d = 1'b0;
            end

            case ({push_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Reset also blocks the write so an in-flight fetch leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            mem_pc[wptr_q]   <= bus.if_pc;
            mem_inst[wptr_q] <= bus.if_inst;
        end
    end

    assign bus.id_pc       = id_pc_q;
    assign bus.id_inst     = id_inst_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.level       = count_q;
    assign bus.stallreq_if = full;

endmodule
